// File: rtl/odesa_neuron_integrator.sv
// Integrate-and-fire neuron: saturating membrane accumulator, threshold fire, refractory hold.
// Optional periodic leak is compiled in with the ODESA_NEURON_LEAK_EN macro.
module odesa_neuron_integrator #(
  parameter int p_sum_width     = 17,
  parameter int p_pot_width     = 20,
  parameter int p_leak_shift    = 4,
  parameter int p_refrac_cycles = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [p_sum_width-1:0] i_sum,
  input  logic                   i_sum_valid,
  output logic                   o_ready,
  input  logic [p_pot_width-1:0] i_threshold,
  input  logic                   i_tick,
  input  logic                   i_clear,
  output logic                   o_spike,
  output logic [p_pot_width-1:0] o_potential,
  output logic [15:0]            o_spike_cnt
);

  // state  | meaning
  // INTEG  | accepting sums, potential integrates (and leaks on tick when built)
  // REFRAC | post-fire hold: not ready, potential pinned at 0, counter runs down

  localparam int CNT_W = (p_refrac_cycles > 0) ? $clog2(p_refrac_cycles + 1) : 1;
  localparam logic [CNT_W-1:0]       REFRAC_LOAD = CNT_W'(p_refrac_cycles);
  localparam logic [p_pot_width-1:0] POT_MAX     = '1;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       refrac_cnt, refrac_cnt_nxt;
  logic [p_pot_width-1:0] potential, potential_nxt;
  logic [p_pot_width-1:0] lp, np;
  logic [p_pot_width:0]   sum_wide;
  logic                   accept, fire;

  assign o_ready     = (state == INTEG) && !i_clear;
  assign accept      = i_sum_valid && o_ready;
  assign o_potential = potential;

`ifdef ODESA_NEURON_LEAK_EN
  assign lp = i_tick ? (potential - (potential >> p_leak_shift)) : potential;
`else
  logic unused_tick;
  assign unused_tick = i_tick;
  assign lp          = potential;
`endif

  // Leak first, then add; one extra bit catches overflow for saturation.
  assign sum_wide = {1'b0, lp} + {{(p_pot_width + 1 - p_sum_width){1'b0}}, i_sum};
  assign np       = sum_wide[p_pot_width] ? POT_MAX : sum_wide[p_pot_width-1:0];
  assign fire     = accept && (np >= i_threshold);

  always_comb begin
    state_nxt      = state;
    refrac_cnt_nxt = refrac_cnt;
    potential_nxt  = potential;
    if (i_clear) begin
      state_nxt      = INTEG;
      refrac_cnt_nxt = '0;
      potential_nxt  = '0;
    end else begin
      case (state)
        INTEG: begin
          if (fire) begin
            potential_nxt = '0;
            if (p_refrac_cycles > 0) begin
              state_nxt      = REFRAC;
              refrac_cnt_nxt = REFRAC_LOAD;
            end
          end else if (accept) begin
            potential_nxt = np;
          end else begin
            potential_nxt = lp;
          end
        end
        REFRAC: begin
          potential_nxt = '0;
          if (refrac_cnt <= CNT_W'(1)) begin
            state_nxt      = INTEG;
            refrac_cnt_nxt = '0;
          end else begin
            refrac_cnt_nxt = refrac_cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt      = INTEG;
          refrac_cnt_nxt = '0;
          potential_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= INTEG;
      refrac_cnt  <= '0;
      potential   <= '0;
      o_spike     <= 1'b0;
      o_spike_cnt <= '0;
    end else begin
      state      <= state_nxt;
      refrac_cnt <= refrac_cnt_nxt;
      potential  <= potential_nxt;
      // fire is already blocked during clear because o_ready drops
      o_spike    <= fire;
      if (i_clear) begin
        o_spike_cnt <= '0;
      end else if (fire) begin
        o_spike_cnt <= o_spike_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_odesa_neuron_integrator.sv
// Self-checking bench: two integrators (refractory 8 and 0) driven in lockstep against a cycle model.
module tb_odesa_neuron_integrator;

`ifdef ODESA_NEURON_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif
  localparam longint POT_MAX = (64'd1 << 20) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] sum;
  logic        sum_valid;
  logic [19:0] threshold;
  logic        tick;
  logic        clear;
  logic [1:0]  ready;
  logic [1:0]  spike;
  logic [19:0] pot [2];
  logic [15:0] cnt [2];

  int n_chk  = 0;
  int n_fail = 0;

  longint m_pot  [2];
  longint m_spk  [2];
  longint m_cnt  [2];
  longint m_refl [2];
  longint m_rlen [2] = '{8, 0};

  always #5 clk = ~clk;

  odesa_neuron_integrator #(.p_refrac_cycles(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_sum(sum), .i_sum_valid(sum_valid), .o_ready(ready[0]),
    .i_threshold(threshold), .i_tick(tick), .i_clear(clear), .o_spike(spike[0]),
    .o_potential(pot[0]), .o_spike_cnt(cnt[0])
  );

  odesa_neuron_integrator #(.p_refrac_cycles(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_sum(sum), .i_sum_valid(sum_valid), .o_ready(ready[1]),
    .i_threshold(threshold), .i_tick(tick), .i_clear(clear), .o_spike(spike[1]),
    .o_potential(pot[1]), .o_spike_cnt(cnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pot[k] = 0; m_spk[k] = 0; m_cnt[k] = 0; m_refl[k] = 0;
    end
  endtask

  // Behaviour of one clock edge, from the rules: refl = cycles of not-ready still to come.
  task automatic model_edge(input bit v, input longint s, input longint th, input bit t, input bit c);
    longint lp, np;
    bit acc, fire;
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_pot[k] = 0; m_spk[k] = 0; m_cnt[k] = 0; m_refl[k] = 0;
      end else if (m_refl[k] > 0) begin
        m_refl[k]--; m_pot[k] = 0; m_spk[k] = 0;
      end else begin
        lp   = (LEAK && t) ? m_pot[k] - (m_pot[k] / 16) : m_pot[k];
        acc  = v;
        np   = acc ? ((lp + s > POT_MAX) ? POT_MAX : lp + s) : lp;
        fire = acc && (np >= th);
        m_spk[k] = fire;
        if (fire) begin
          m_pot[k]  = 0;
          m_cnt[k]  = (m_cnt[k] + 1) % 65536;
          m_refl[k] = m_rlen[k];
        end else begin
          m_pot[k] = np;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_pot%0d", tag, k), 32'(pot[k]), 32'(m_pot[k]));
      chk($sformatf("%s_spk%0d", tag, k), 32'(spike[k]), 32'(m_spk[k]));
      chk($sformatf("%s_cnt%0d", tag, k), 32'(cnt[k]), 32'(m_cnt[k]));
    end
  endtask

  // Called at posedge+1: drive, check ready, clock, check registered outputs.
  task automatic step(input string tag, input bit v, input logic [16:0] s, input logic [19:0] th,
                      input bit t, input bit c, input bit do_chk);
    sum = s; sum_valid = v; threshold = th; tick = t; clear = c;
    #1;
    if (do_chk) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("%s_rdy%0d", tag, k), 32'(ready[k]), 32'(m_refl[k] == 0 && !c));
    end
    @(posedge clk);
    model_edge(v, longint'(s), longint'(th), t, c);
    #1;
    if (do_chk) check_all(tag);
  endtask

  initial begin
    rst = 1'b1; sum = '0; sum_valid = 1'b0; threshold = '0; tick = 1'b0; clear = 1'b0;
    model_reset();
    #1;
    chk("reset_rdy0", 32'(ready[0]), 32'd1);
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // accumulate to fire, then hold valid through refractory
    step("acc1", 1, 17'd300, 20'd1000, 0, 0, 1);
    step("acc2", 1, 17'd300, 20'd1000, 0, 0, 1);
    step("acc3", 1, 17'd300, 20'd1000, 0, 0, 1);
    chk("acc900", 32'(pot[0]), 32'd900);
    step("fire", 1, 17'd200, 20'd1000, 0, 0, 1);
    chk("fire_spk", 32'(spike[0]), 32'd1);
    for (int i = 0; i < 9; i++) step("refrac", 1, 17'd200, 20'd1000, 0, 0, 1);
    chk("fire_cnt", 32'(cnt[0]), 32'd1);

    // saturation
    step("clr", 0, 17'd0, 20'hFFFFF, 0, 1, 1);
    for (int i = 0; i < 12; i++) step("sat", 1, 17'h1FFFF, 20'hFFFFF, 0, 0, 1);

    // leak
    step("clr", 0, 17'd0, 20'hFFFFF, 0, 1, 1);
    step("pre1600", 1, 17'd1600, 20'hFFFFF, 0, 0, 1);
    step("tick", 0, 17'd0, 20'hFFFFF, 1, 0, 1);
    chk("tick_pot", 32'(pot[0]), LEAK ? 32'd1500 : 32'd1600);
    step("tickacc", 1, 17'd100, 20'hFFFFF, 1, 0, 1);
    chk("tickacc_pot", 32'(pot[0]), LEAK ? 32'd1507 : 32'd1700);
    for (int i = 0; i < 10; i++) step("ticks", 0, 17'd0, 20'hFFFFF, 1, 0, 1);

    // async reset mid-refractory
    step("clr", 0, 17'd0, 20'd10, 0, 1, 1);
    step("rfire", 1, 17'd50, 20'd10, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("rwait", 0, 17'd0, 20'd10, 0, 0, 1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rdy0", 32'(ready[0]), 32'd1);
    check_all("arst");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // refractory 0: consecutive fires
    step("b2b1", 1, 17'd0, 20'd0, 0, 0, 1);
    chk("b2b1_spk1", 32'(spike[1]), 32'd1);
    step("b2b2", 1, 17'd0, 20'd0, 0, 0, 1);
    chk("b2b2_spk1", 32'(spike[1]), 32'd1);
    chk("b2b2_cnt1", 32'(cnt[1]), 32'd2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 17'($urandom_range(0, 17'h1FFFF) >> $urandom_range(0, 12)),
           20'($urandom_range(0, 20'hFFFFF) >> $urandom_range(0, 10)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0), 1);
    end

    // wrap and clear
    step("clr", 0, 17'd0, 20'd0, 0, 1, 1);
    for (int i = 0; i < 65535; i++) step("pre", 1, 17'd0, 20'd0, 0, 0, 0);
    check_all("preload");
    chk("pre_ffff", 32'(cnt[1]), 32'hFFFF);
    step("wrap", 1, 17'd0, 20'd0, 0, 0, 1);
    chk("wrap_zero", 32'(cnt[1]), 32'd0);
    step("acc", 1, 17'd5, 20'd100, 0, 0, 1);
    step("clrv", 1, 17'd5, 20'd0, 0, 1, 1);
    chk("clrv_cnt0", 32'(cnt[0]), 32'd0);
    chk("clrv_pot1", 32'(pot[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
